// File: rtl/qeciphy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qeciphy_pkg
// Description : Shared QECIPHY constants and types. Defines the RX training
//               word layout, which the TX framer also uses. Also defines the
//               RX lock monitor state encoding and a training-word matcher.
// Revision    : 1.0 - initial release
// ============================================================================
package qeciphy_pkg;

    // Training word layout: [63:8] magic, [7:1] zero pad, [0] sender ready.
    localparam logic [55:0] c_TRAIN_MAGIC   = 56'hA5C3_5A3C_96E1_0F;
    localparam int          c_MAGIC_MSB     = 63;
    localparam int          c_MAGIC_LSB     = 8;
    localparam int          c_PAD_MSB       = 7;
    localparam int          c_PAD_LSB       = 1;
    localparam int          c_RDY_FLAG_BIT  = 0;

    typedef enum logic [2:0] {
        RX_DISABLED     = 3'd0,
        RX_HUNT         = 3'd1,
        RX_LOCKED       = 3'd2,
        RX_REMOTE_READY = 3'd3,
        RX_FAULT        = 3'd4
    } rx_lock_state_t;

    // True when the word carries the training magic and a clean pad field.
    // The ready flag is deliberately ignored here.
    function automatic logic is_train_word(input logic [63:0] word);
        return (word[c_MAGIC_MSB:c_MAGIC_LSB] == c_TRAIN_MAGIC) &&
               (word[c_PAD_MSB:c_PAD_LSB] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qeciphy_rx_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : qeciphy_rx_lock_monitor
// Description : RX link-training monitor. It hunts for consecutive training
//               words and asserts local lock. It then waits for the remote
//               ready flag and asserts remote ready. It raises a sticky fatal
//               fault on training timeout or on repeated corrupt words.
// Ports       : clk_i, rst_i (sync, active-high)
//               rx_enable_i          - RX enable from controller
//               rx_tdata_i/tvalid_i  - aligned 64-bit RX word stream
//               rx_ready_o           - local RX lock
//               remote_rx_ready_o    - remote side reports RX locked
//               fault_fatal_o        - sticky fatal fault
//               state_o              - FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module qeciphy_rx_lock_monitor
    import qeciphy_pkg::*;
#(
    parameter int LOCK_COUNT     = 8,
    parameter int REMOTE_COUNT   = 4,
    parameter int MAX_ERRORS     = 3,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_enable_i,
    input  logic [63:0] rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_ready_o,
    output logic        remote_rx_ready_o,
    output logic        fault_fatal_o,
    output logic [2:0]  state_o
);

    localparam int c_LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int c_REM_W  = $clog2(REMOTE_COUNT + 1);
    localparam int c_ERR_W  = $clog2(MAX_ERRORS + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Counter values that, combined with one more event, complete a goal.
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_COUNT - 1);
    localparam logic [c_REM_W-1:0]  c_REM_LAST  = c_REM_W'(REMOTE_COUNT - 1);
    localparam logic [c_ERR_W-1:0]  c_ERR_LAST  = c_ERR_W'(MAX_ERRORS - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);

    rx_lock_state_t      r_state;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic [c_REM_W-1:0]  r_rem_cnt;
    logic [c_ERR_W-1:0]  r_err_cnt;
    logic [c_TMO_W-1:0]  r_tmo_cnt;

    logic w_match;
    logic w_good;
    logic w_bad;
    logic w_flag;
    logic w_tmo_expired;

    assign w_match       = is_train_word(rx_tdata_i);
    assign w_good        = rx_tvalid_i &&  w_match;
    assign w_bad         = rx_tvalid_i && !w_match;
    assign w_flag        = rx_tdata_i[c_RDY_FLAG_BIT];
    assign w_tmo_expired = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= RX_DISABLED;
            r_lock_cnt <= '0;
            r_rem_cnt  <= '0;
            r_err_cnt  <= '0;
            r_tmo_cnt  <= '0;
        end else if (r_state == RX_FAULT) begin
            // Sticky until reset, regardless of enable.
            r_state <= RX_FAULT;
        end else if (!rx_enable_i) begin
            r_state    <= RX_DISABLED;
            r_lock_cnt <= '0;
            r_rem_cnt  <= '0;
            r_err_cnt  <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_state)
                RX_DISABLED: begin
                    r_state    <= RX_HUNT;
                    r_tmo_cnt  <= '0;
                    r_lock_cnt <= '0;
                end
                RX_HUNT: begin
                    if (!w_tmo_expired) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_good) begin
                        if (r_lock_cnt != c_LOCK_W'(LOCK_COUNT))
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                    end else if (w_bad) begin
                        r_lock_cnt <= '0;
                    end
                    // A lock-completing word wins over an expiring timeout.
                    if (w_good && (r_lock_cnt == c_LOCK_LAST))
                        r_state <= RX_LOCKED;
                    else if (w_tmo_expired)
                        r_state <= RX_FAULT;
                end
                RX_LOCKED: begin
                    if (!w_tmo_expired) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_good) begin
                        r_err_cnt <= '0;
                        if (w_flag) begin
                            if (r_rem_cnt != c_REM_W'(REMOTE_COUNT))
                                r_rem_cnt <= r_rem_cnt + 1'b1;
                        end else begin
                            r_rem_cnt <= '0;
                        end
                    end else if (w_bad) begin
                        r_rem_cnt <= '0;
                        if (r_err_cnt != c_ERR_W'(MAX_ERRORS))
                            r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (w_good && w_flag && (r_rem_cnt == c_REM_LAST))
                        r_state <= RX_REMOTE_READY;
                    else if (w_bad && (r_err_cnt == c_ERR_LAST))
                        r_state <= RX_FAULT;
                    else if (w_tmo_expired)
                        r_state <= RX_FAULT;
                end
                RX_REMOTE_READY: begin
                    // Remote may now send user data; stop checking words.
                    r_state <= RX_REMOTE_READY;
                end
                default: begin
                    r_state <= RX_DISABLED;
                end
            endcase
        end
    end

    assign rx_ready_o        = (r_state == RX_LOCKED) || (r_state == RX_REMOTE_READY);
    assign remote_rx_ready_o = (r_state == RX_REMOTE_READY);
    assign fault_fatal_o     = (r_state == RX_FAULT);
    assign state_o           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_qeciphy_rx_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_qeciphy_rx_lock_monitor
// Description : Self-checking bench for qeciphy_rx_lock_monitor. Each scenario
//               builds a per-cycle stimulus table with the expected state
//               after that clock edge. Expected values go into a scoreboard
//               queue as each cycle is driven. They are popped and compared
//               against the outputs once the DUT has updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qeciphy_rx_lock_monitor;

    localparam int          TMO   = 64;
    localparam logic [55:0] MAGIC = 56'hA5C3_5A3C_96E1_0F;
    localparam logic [2:0]  S_DIS = 3'd0, S_HUNT = 3'd1, S_LOCK = 3'd2,
                            S_REM = 3'd3, S_FLT  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vld;
    logic [63:0] dat;
    logic        rx_ready_o;
    logic        remote_rx_ready_o;
    logic        fault_fatal_o;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic        v;
        logic [63:0] d;
        logic [2:0]  exp;
    } stim_t;

    stim_t      sq[$];
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    qeciphy_rx_lock_monitor #(
        .LOCK_COUNT     (8),
        .REMOTE_COUNT   (4),
        .MAX_ERRORS     (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rx_enable_i       (en),
        .rx_tdata_i        (dat),
        .rx_tvalid_i       (vld),
        .rx_ready_o        (rx_ready_o),
        .remote_rx_ready_o (remote_rx_ready_o),
        .fault_fatal_o     (fault_fatal_o),
        .state_o           (state_o)
    );

    function automatic logic [63:0] gw(input logic flag);
        return {MAGIC, 7'd0, flag};
    endfunction

    // {rx_ready, remote_ready, fault, state} implied by a state value.
    function automatic logic [5:0] expv(input logic [2:0] s);
        return {(s == S_LOCK) || (s == S_REM), s == S_REM, s == S_FLT, s};
    endfunction

    task automatic add(input logic r, input logic e, input logic v,
                       input logic [63:0] d, input logic [2:0] exp);
        stim_t s;
        s.r = r; s.e = e; s.v = v; s.d = d; s.exp = exp;
        sq.push_back(s);
    endtask

    task automatic addn(input int n, input logic e, input logic v,
                        input logic [63:0] d, input logic [2:0] exp);
        for (int i = 0; i < n; i++) add(1'b0, e, v, d, exp);
    endtask

    // Drive one table entry per cycle; score after the edge.
    task automatic drive_one(output logic [2:0] exp);
        stim_t s;
        s   = sq.pop_front();
        rst = s.r; en = s.e; vld = s.v; dat = s.d;
        exp_q.push_back(s.exp);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
    endtask

    task automatic test_reset;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        addn(3, 1'b0, 1'b0, 64'd0, S_DIS);
        addn(2, 1'b0, 1'b1, gw(1'b1), S_DIS);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL reset step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_lock;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        addn(3, 1'b1, 1'b0, 64'd0, S_LOCK);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL lock step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_broken_run;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, {MAGIC, 8'h02}, S_HUNT);      // pad bit set
        for (int k = 0; k < 8; k++) begin
            add(1'b0, 1'b1, 1'b1, gw(k[0]), (k == 7) ? S_LOCK : S_HUNT);
            if (k == 2 || k == 5) addn(2, 1'b1, 1'b0, 64'hDEAD, S_HUNT);
        end
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL broken_run step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_remote;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        addn(3, 1'b1, 1'b1, gw(1'b1), S_LOCK);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);            // clears remote run
        add(1'b0, 1'b1, 1'b1, gw(1'b1), S_LOCK);
        addn(2, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, S_LOCK);
        add(1'b0, 1'b1, 1'b1, gw(1'b1), S_LOCK);            // clears errors
        addn(2, 1'b1, 1'b1, 64'h0, S_LOCK);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        addn(3, 1'b1, 1'b1, gw(1'b1), S_LOCK);
        add(1'b0, 1'b1, 1'b1, gw(1'b1), S_REM);
        for (int k = 0; k < 100; k++)
            add(1'b0, 1'b1, 1'b1, {$urandom(), $urandom()}, S_REM);
        addn(3, 1'b1, 1'b0, 64'd0, S_REM);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL remote step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_error_fault;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        addn(2, 1'b1, 1'b1, {~MAGIC, 8'h00}, S_LOCK);
        add(1'b0, 1'b1, 1'b1, {~MAGIC, 8'h00}, S_FLT);
        addn(3, 1'b0, 1'b0, 64'd0, S_FLT);
        add(1'b0, 1'b1, 1'b1, gw(1'b1), S_FLT);
        add(1'b1, 1'b1, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b0, 1'b0, 64'd0, S_DIS);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL error_fault step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_timeout;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        // No valid words: the 64th cycle spent in HUNT trips the fault.
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(TMO - 1, 1'b1, 1'b0, 64'd0, S_HUNT);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_FLT);
        addn(2, 1'b1, 1'b0, 64'd0, S_FLT);
        // Lock-completing word lands exactly on the timeout cycle.
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(TMO - 8, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        add(1'b0, 1'b0, 1'b0, 64'd0, S_DIS);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL timeout step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] e;
        logic [5:0] got;
        int step = 0;
        add(1'b1, 1'b0, 1'b0, 64'd0, S_DIS);
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        addn(3, 1'b1, 1'b1, gw(1'b1), S_LOCK);
        add(1'b0, 1'b1, 1'b1, gw(1'b1), S_REM);
        add(1'b0, 1'b0, 1'b1, gw(1'b1), S_DIS);             // one-cycle disable
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(5, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b0, 1'b0, 64'd0, S_DIS);                // partial run discarded
        add(1'b0, 1'b1, 1'b0, 64'd0, S_HUNT);
        addn(7, 1'b1, 1'b1, gw(1'b0), S_HUNT);
        add(1'b0, 1'b1, 1'b1, gw(1'b0), S_LOCK);
        while (sq.size() > 0) begin
            drive_one(e);
            got = {rx_ready_o, remote_rx_ready_o, fault_fatal_o, state_o};
            total++;
            if (got !== expv(e)) begin
                bad++;
                $display("FAIL back_to_back step %0d: got %b want %b", step, got, expv(e));
            end
            step++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        vld = 1'b0;
        dat = 64'd0;
        test_reset();
        test_lock();
        test_broken_run();
        test_remote();
        test_error_fault();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
